decoder_seq: RTL and testbench
==============================

# decoder_seq

Registered, parametrised binary-to-one-hot decoder with a timed output strobe. It generalises the 3-to-8 combinational decoder to 2^SEL_W outputs. A valid/ready command interface loads a select value and a dwell length. The block then holds the decoded line for that many cycles, or walks through every line in turn (scan mode), and signals completion. It sits between a control sequencer and one-hot enable/strobe consumers such as bank selects and mux enables.

## Interface
- SEL_W, default 3: select width; output width OUT_W = 2^SEL_W (derived, not overridable); legal 1..6
- LEN_W, default 8: dwell-length field width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when in_valid & in_ready at a clk edge
- in_sel  in  SEL_W  start line index
- in_len  in  LEN_W  dwell cycles per line; 0 treated as 1
- in_mode  in  1  0 = single, 1 = scan
- abort  in  1  synchronous cancel
- out_onehot  out  OUT_W  registered one-hot output; all-zero when idle
- out_valid  out  1  out_onehot is driving a line
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, DRIVE. Reset value is IDLE.
- in_ready = (state == IDLE) & ~abort. This is combinational; no other input feeds it.
- Accept in IDLE: latch idx = in_sel, L = max(in_len, 1), mode. Go to DRIVE. Load dwell counter = L-1 and step counter = 0.
- DRIVE: out_onehot = 1 << idx, out_valid = 1, busy = 1.
  - Dwell counter decrements each cycle.
  - At dwell == 0 in single mode, or in scan mode with step == OUT_W-1: assert done this cycle, return to IDLE.
  - At dwell == 0 in scan mode otherwise: idx = (idx + 1) mod OUT_W (wraps from OUT_W-1 to 0), step += 1, reload dwell = L-1.
- The step counter is SEL_W+1 bits wide. Scan mode always covers all OUT_W lines exactly once, starting at in_sel.
- abort in DRIVE: next cycle state = IDLE and outputs = 0; done is not asserted. abort in IDLE: no effect, and it blocks acceptance that cycle.
- abort and the final dwell cycle together: abort wins, so done = 0.
- Inputs are ignored while in DRIVE; in_sel, in_len and in_mode need only be stable at the accept edge.

## Timing
- Reset (async assert, sync to release on the next edge): out_onehot = 0, out_valid = 0, busy = 0, done = 0, in_ready = 1 once rst_n is high.
- Accept at edge T. out_onehot becomes valid in cycle T+1 (1-cycle latency).
- Single mode: line held for cycles T+1..T+L. done is high in cycle T+L. The cycle after that has outputs = 0 and in_ready = 1. The next accept is possible at the edge ending cycle T+L+1, giving a minimum of L+1 cycles per command.
- Scan mode: OUT_W*L drive cycles. Line k (k = 0..OUT_W-1) is driven in cycles T+1+k*L .. T+(k+1)*L. done is high in cycle T+OUT_W*L.
- Line changes between consecutive scan steps have no gap cycle and no overlap. out_onehot has at most one bit high in every cycle.
- done is never high in IDLE. busy equals out_valid.

## Configuration
- DECODER_SEQ_SCAN_EN defined: scan mode is implemented as described.
- DECODER_SEQ_SCAN_EN undefined:
  - in_mode is ignored and every command runs in single mode.
  - The step counter and increment logic are removed.
  - Timing of single mode is identical in both builds.

## Test plan
- Reset: assert rst_n = 0 mid-DRIVE (SEL_W=3, sel=5, len=10) -> out_onehot = 0, out_valid = 0, busy = 0 immediately, without waiting for a clock edge. After release, in_ready = 1.
- Single: sel=5, len=3, mode=0 accepted at T -> out_onehot = 8'b0010_0000 in T+1..T+3; done only in T+3; in_ready = 1 in T+4.
- len=0: sel=0, len=0 -> 8'b0000_0001 for exactly 1 cycle, done in that same cycle.
- Scan with wrap: sel=6, len=2, mode=1 -> lines 6,6,7,7,0,0,1,1,...,5,5 (16 cycles); done in the 16th cycle; a one-hot check passes every cycle. With the macro undefined, the same stimulus gives line 6 for 2 cycles and then done.
- Abort: scan sel=0, len=4, abort asserted in cycle T+6 -> outputs 0 from T+7, done never asserted, in_ready = 0 during the abort cycle. Then issue abort and in_valid together in IDLE -> no accept.
- Back-to-back: hold in_valid high with two single commands (sel=1, len=1, then sel=2, len=1) -> line 1 in T+1, idle gap in T+2, line 2 in T+3.

Source files
------------

// File: rtl/decoder_seq.sv
// Registered binary-to-one-hot decoder with a dwell timer and optional scan-through-all-lines mode.
// Define DECODER_SEQ_SCAN_EN to build scan mode; otherwise every command runs in single mode.
module decoder_seq #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned LEN_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [SEL_W-1:0]      in_sel_i,
    input  logic [LEN_W-1:0]      in_len_i,
    input  logic                  in_mode_i,
    input  logic                  abort_i,
    output logic [2**SEL_W-1:0]   out_onehot_o,
    output logic                  out_valid_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned OUT_W = 2**SEL_W;

    typedef enum logic [0:0] {StIdle, StDrive} state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] reload_q, reload_d;
    logic [LEN_W-1:0] dwell_q, dwell_d;
    logic [OUT_W-1:0] onehot_q, onehot_d;
    logic [LEN_W-1:0] len_m1;
    logic             last_step;
    logic             done;

`ifdef DECODER_SEQ_SCAN_EN
    localparam logic [SEL_W:0] StepLast = (SEL_W+1)'(OUT_W - 1);

    logic             mode_q, mode_d;
    logic [SEL_W:0]   step_q, step_d;

    assign last_step = ~mode_q | (step_q == StepLast);
`else
    logic unused_mode;

    assign unused_mode = in_mode_i;
    assign last_step   = 1'b1;
`endif

    // A zero length behaves as a one-cycle dwell.
    assign len_m1 = (in_len_i == '0) ? '0 : in_len_i - LEN_W'(1);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        reload_d = reload_q;
        dwell_d  = dwell_q;
        done     = 1'b0;
`ifdef DECODER_SEQ_SCAN_EN
        mode_d   = mode_q;
        step_d   = step_q;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid_i && !abort_i) begin
                    state_d  = StDrive;
                    idx_d    = in_sel_i;
                    reload_d = len_m1;
                    dwell_d  = len_m1;
`ifdef DECODER_SEQ_SCAN_EN
                    mode_d   = in_mode_i;
                    step_d   = '0;
`endif
                end
            end
            StDrive: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (dwell_q != '0) begin
                    dwell_d = dwell_q - LEN_W'(1);
                end else if (last_step) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end else begin
                    // Index width equals log2(OUT_W), so the add wraps naturally.
                    idx_d   = idx_q + SEL_W'(1);
                    dwell_d = reload_q;
`ifdef DECODER_SEQ_SCAN_EN
                    step_d  = step_q + (SEL_W+1)'(1);
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        onehot_d = (state_d == StDrive) ? (OUT_W'(1) << idx_d) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            reload_q <= '0;
            dwell_q  <= '0;
            onehot_q <= '0;
`ifdef DECODER_SEQ_SCAN_EN
            mode_q   <= 1'b0;
            step_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            reload_q <= reload_d;
            dwell_q  <= dwell_d;
            onehot_q <= onehot_d;
`ifdef DECODER_SEQ_SCAN_EN
            mode_q   <= mode_d;
            step_q   <= step_d;
`endif
        end
    end

    assign in_ready_o   = (state_q == StIdle) & ~abort_i;
    assign out_onehot_o = onehot_q;
    assign out_valid_o  = (state_q == StDrive);
    assign busy_o       = (state_q == StDrive);
    assign done_o       = done;

endmodule

// File: tb/tb_decoder_seq.sv
// Self-checking bench for decoder_seq: directed scenarios plus random commands checked against
// a per-cycle expected-line list built from the command fields.
module tb_decoder_seq;

    localparam int SEL_W = 3;
    localparam int LEN_W = 8;
    localparam int OUT_W = 8;
`ifdef DECODER_SEQ_SCAN_EN
    localparam bit ScanEn = 1'b1;
`else
    localparam bit ScanEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [SEL_W-1:0] in_sel = '0;
    logic [LEN_W-1:0] in_len = '0;
    logic             in_mode = 1'b0;
    logic             abort = 1'b0;
    logic [OUT_W-1:0] out_onehot;
    logic             out_valid;
    logic             busy;
    logic             done;

    int checks = 0;
    int failures = 0;

    decoder_seq #(.SEL_W(SEL_W), .LEN_W(LEN_W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_sel_i    (in_sel),
        .in_len_i    (in_len),
        .in_mode_i   (in_mode),
        .abort_i     (abort),
        .out_onehot_o(out_onehot),
        .out_valid_o (out_valid),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".onehot"}, 64'(out_onehot), 64'd0);
        chk({tag, ".valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".done"}, 64'(done), 64'd0);
        chk({tag, ".ready"}, 64'(in_ready), 64'(!abort));
    endtask

    // Issues one command and checks every cycle until it ends; abort_at is the drive-cycle
    // index (0-based) in which abort is raised, or -1. hold keeps in_valid high afterwards.
    task automatic run_cmd(input string tag, input int sel, input int len, input bit mode,
                           input int abort_at, input bit hold);
        int lines[$];
        int l_eff;
        int n_lines;
        bit ab;
        l_eff   = (len == 0) ? 1 : len;
        n_lines = (mode && ScanEn) ? OUT_W : 1;
        for (int k = 0; k < n_lines; k++)
            for (int c = 0; c < l_eff; c++) lines.push_back((sel + k) % OUT_W);

        in_sel   = SEL_W'(sel);
        in_len   = LEN_W'(len);
        in_mode  = mode;
        in_valid = 1'b1;
        #1;
        chk({tag, ".ready_pre"}, 64'(in_ready), 64'd1);
        tick();
        if (!hold) in_valid = 1'b0;
        for (int i = 0; i < lines.size(); i++) begin
            ab    = (i == abort_at);
            abort = ab;
            #1;
            chk({tag, ".onehot"}, 64'(out_onehot), 64'd1 << lines[i]);
            chk({tag, ".valid"}, 64'(out_valid), 64'd1);
            chk({tag, ".busy"}, 64'(busy), 64'd1);
            chk({tag, ".done"}, 64'(done), 64'(!ab && (i == lines.size() - 1)));
            chk({tag, ".ready"}, 64'(in_ready), 64'd0);
            tick();
            abort = 1'b0;
            if (ab) break;
        end
        #1;
        check_idle({tag, ".after"});
    endtask

    initial begin
        int sel;
        int len;
        int mode;
        int ab_at;

        #1 rst_n = 1'b0;
        #1;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_idle("post_reset");

        run_cmd("single", 5, 3, 1'b0, -1, 1'b0);
        run_cmd("len0", 0, 0, 1'b0, -1, 1'b0);
        run_cmd("scan_wrap", 6, 2, 1'b1, -1, 1'b0);
        run_cmd("scan_abort", 0, 4, 1'b1, 5, 1'b0);

        abort    = 1'b1;
        in_valid = 1'b1;
        in_sel   = 3'd3;
        in_len   = 8'd2;
        #1;
        chk("abort_idle.ready", 64'(in_ready), 64'd0);
        tick();
        in_valid = 1'b0;
        abort    = 1'b0;
        #1;
        check_idle("abort_idle.no_accept");

        run_cmd("b2b_first", 1, 1, 1'b0, -1, 1'b1);
        run_cmd("b2b_second", 2, 1, 1'b0, -1, 1'b1);
        in_valid = 1'b0;
        tick();

        for (int n = 0; n < 40; n++) begin
            sel   = int'($urandom_range(0, OUT_W - 1));
            len   = int'($urandom_range(0, 4));
            mode  = int'($urandom_range(0, 1));
            ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
            run_cmd("random", sel, len, mode[0], ab_at, 1'b0);
        end

        in_sel   = 3'd5;
        in_len   = 8'd10;
        in_mode  = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #1;
        chk("mid_drive.valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset.onehot", 64'(out_onehot), 64'd0);
        chk("async_reset.valid", 64'(out_valid), 64'd0);
        chk("async_reset.busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_idle("after_async_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
